// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: single-outstanding initiator for the Enable/MOV/RW/MOC
// memory handshake. It accepts a CPU request in IDLE, presents it to memory,
// waits for the MOC rise and fall (resynchronised), and pulses Done.
// Optional feature macro: MEM_TIMEOUT_EN adds a per-edge MOC wait timeout
// that aborts the transfer with Done and Error both pulsed.
module mem_bus_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ReqRW,
  input  logic [7:0]  ReqAddr,
  input  logic [31:0] ReqData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] RdData,
  output logic        Enable,
  output logic        MOV,
  output logic        RW,
  output logic [7:0]  Address,
  output logic [31:0] MemDataOut,
  input  logic [31:0] MemDataIn,
  input  logic        MOC
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t state_r;
  logic   moc_meta_r;
  logic   moc_sync_r;

`ifdef MEM_TIMEOUT_EN
  // Counter is at least 8 bits so the default TIMEOUT fits without change.
  localparam int CNT_W = (TIMEOUT > 32'd255) ? $clog2(TIMEOUT + 32'd1) : 8;
  // The counter reads TIMEOUT-1 on the edge that marks TIMEOUT cycles spent
  // in the waiting state, so that edge is the one that enters DONE.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  logic [CNT_W-1:0] wait_cnt_r;
`endif

  // Two-flop resynchroniser for the asynchronous MOC completion input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      moc_meta_r <= 1'b0;
      moc_sync_r <= 1'b0;
    end else begin
      moc_meta_r <= MOC;
      moc_sync_r <= moc_meta_r;
    end
  end

  // Transfer FSM; every memory-side and CPU-side output is registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      RdData     <= 32'h0000_0000;
      Enable     <= 1'b0;
      MOV        <= 1'b0;
      RW         <= 1'b0;
      Address    <= 8'h00;
      MemDataOut <= 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_r <= '0;
`endif
    end else begin
      // Done and Error are single-cycle pulses unless re-asserted below.
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          Enable <= 1'b0;
          MOV    <= 1'b0;
          if (Req) begin
            RW         <= ReqRW;
            Address    <= ReqAddr;
            MemDataOut <= ReqData;
            Busy       <= 1'b1;
            Enable     <= 1'b1;
            state_r    <= ST_SETUP;
          end else begin
            Busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          MOV     <= 1'b1;
          state_r <= ST_STROBE;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_r <= '0;
`endif
        end

        ST_STROBE: begin
`ifdef MEM_TIMEOUT_EN
          // Timeout wins over a completion seen on the same edge.
          if (wait_cnt_r == CNT_LAST) begin
            Enable  <= 1'b0;
            MOV     <= 1'b0;
            Done    <= 1'b1;
            Error   <= 1'b1;
            state_r <= ST_DONE;
          end else
`endif
          if (moc_sync_r) begin
            if (RW) begin
              RdData <= MemDataIn;
            end else begin
              RdData <= RdData;
            end
            MOV     <= 1'b0;
            state_r <= ST_HOLD;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_r <= '0;
`endif
          end else begin
            state_r <= ST_STROBE;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
`endif
          end
        end

        ST_HOLD: begin
`ifdef MEM_TIMEOUT_EN
          if (wait_cnt_r == CNT_LAST) begin
            Enable  <= 1'b0;
            MOV     <= 1'b0;
            Done    <= 1'b1;
            Error   <= 1'b1;
            state_r <= ST_DONE;
          end else
`endif
          if (!moc_sync_r) begin
            Enable  <= 1'b0;
            Done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_HOLD;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
`endif
          end
        end

        ST_DONE: begin
          Enable  <= 1'b0;
          MOV     <= 1'b0;
          Busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          Enable  <= 1'b0;
          MOV     <= 1'b0;
          Busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Self-checking bench for mem_bus_initiator: directed scenarios plus
// randomized transfers against a request-level memory reference model.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_bus_initiator;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        ReqRW;
  logic [7:0]  ReqAddr;
  logic [31:0] ReqData;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [31:0] RdData;
  logic        Enable;
  logic        MOV;
  logic        RW;
  logic [7:0]  Address;
  logic [31:0] MemDataOut;
  logic [31:0] MemDataIn;
  logic        MOC;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Responder-side RAM and the bench's independent expectation of it.
  logic [31:0] memory  [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd;

  // Responder controls and bookkeeping.
  bit resp_en;
  int resp_delay;
  int resp_width;
  int fall_cyc;

  mem_bus_initiator #(.TIMEOUT(8)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqRW(ReqRW), .ReqAddr(ReqAddr),
    .ReqData(ReqData), .Busy(Busy), .Done(Done), .Error(Error),
    .RdData(RdData), .Enable(Enable), .MOV(MOV), .RW(RW), .Address(Address),
    .MemDataOut(MemDataOut), .MemDataIn(MemDataIn), .MOC(MOC)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  assign MemDataIn = memory[Address];

  // Memory responder: waits resp_delay cycles after seeing MOV, raises MOC
  // for resp_width cycles, performs writes, then waits for MOV to drop.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    MOC = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      if (Reset || !resp_en) begin
        MOC = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (MOV) begin phase = 1; cnt = resp_delay; end
          default: ;
        endcase
        if (phase == 1) begin
          if (cnt == 0) begin
            MOC = 1'b1;
            if (!RW) memory[Address] = MemDataOut;
            cnt = resp_width - 1;
            phase = 2;
          end else begin
            cnt = cnt - 1;
          end
        end else if (phase == 2) begin
          if (cnt == 0) begin
            MOC = 1'b0;
            fall_cyc = cyc;
            phase = 3;
          end else begin
            cnt = cnt - 1;
          end
        end else if (phase == 3) begin
          if (!MOV) phase = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer with MOV-phase stability and completion checks.
  task automatic xfer(input logic rw, input logic [7:0] a, input logic [31:0] d,
                      input int dly, input int wid);
    bit got;
    bit stable_ok;
    logic [31:0] exp_rd;
    resp_delay = dly;
    resp_width = wid;
    Req = 1'b1; ReqRW = rw; ReqAddr = a; ReqData = d;
    tick();
    Req = 1'b0;
    got = 1'b0;
    stable_ok = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      if (Done) begin
        got = 1'b1;
      end else begin
        if (MOV && (Address !== a || RW !== rw || (!rw && MemDataOut !== d)))
          stable_ok = 1'b0;
        tick();
      end
    end
    chk("xfer_done_seen", {31'd0, got}, 32'd1);
    chk("xfer_stable", {31'd0, stable_ok}, 32'd1);
    chk("xfer_done_timing", cyc, fall_cyc + 3);
    chk("xfer_error", {31'd0, Error}, 32'd0);
    if (rw) begin
      exp_rd = ref_mem[a];
      last_rd = exp_rd;
    end else begin
      ref_mem[a] = d;
      exp_rd = last_rd;
    end
    chk(rw ? "rd_data" : "wr_rddata_kept", RdData, exp_rd);
    tick();
    chk("done_pulse_len", {30'd0, Done, Busy}, 32'd0);
  endtask

  initial begin
    int dones;
    int gap;
    int extra;
    bit got;
    bit bad;
    int strobe_cyc;
    logic [31:0] rd2;

    for (int i = 0; i < 256; i++) begin
      memory[i]  = 32'h1357_9BDF ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'h1357_9BDF ^ (i * 32'h0101_0101);
    end
    last_rd = 32'h0;
    resp_en = 1'b1; resp_delay = 2; resp_width = 1; fall_cyc = 0;
    Reset = 1'b1; Req = 1'b0; ReqRW = 1'b0; ReqAddr = 8'h00; ReqData = 32'h0;
    repeat (3) tick();
    chk("rst_ctrl", {26'd0, Enable, MOV, RW, Busy, Done, Error}, 32'd0);
    chk("rst_addr", {24'd0, Address}, 32'd0);
    chk("rst_wdata", MemDataOut, 32'd0);
    chk("rst_rddata", RdData, 32'd0);
    Reset = 1'b0;
    tick();

    // Directed write then read at 8'h10.
    xfer(1'b0, 8'h10, 32'hDEAD_BEEF, 2, 1);
    chk("wr_mem_content", memory[8'h10], 32'hDEAD_BEEF);
    memory[8'h10] = 32'hCAFE_F00D;
    ref_mem[8'h10] = 32'hCAFE_F00D;
    xfer(1'b1, 8'h10, 32'h0, 2, 1);
    chk("rd_cafef00d", RdData, 32'hCAFE_F00D);

    // Back-to-back with Req held high: write 8'h01 then read it back.
    resp_delay = 1; resp_width = 1;
    Req = 1'b1; ReqRW = 1'b0; ReqAddr = 8'h01; ReqData = 32'h0000_0055;
    dones = 0; gap = 0; rd2 = 32'h0;
    for (int i = 0; i < 200 && dones < 2; i++) begin
      tick();
      if (dones == 1 && !Busy) gap++;
      if (Done) begin
        dones++;
        if (dones == 1) begin
          ReqRW = 1'b1;
          ReqData = 32'h0;
        end else begin
          Req = 1'b0;
          rd2 = RdData;
        end
      end
    end
    Req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Done) dones++;
    end
    ref_mem[8'h01] = 32'h0000_0055;
    last_rd = 32'h0000_0055;
    chk("b2b_done_count", dones, 32'd2);
    chk("b2b_rddata", rd2, 32'h0000_0055);
    chk("b2b_idle_gap", gap, 32'd1);

    // Request pulsed during STROBE must be ignored.
    resp_delay = 3; resp_width = 1;
    Req = 1'b1; ReqRW = 1'b0; ReqAddr = 8'h20; ReqData = 32'h1234_5678;
    tick();
    Req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (MOV) got = 1'b1; else tick();
    end
    chk("ign_mov_seen", {31'd0, got}, 32'd1);
    Req = 1'b1; ReqRW = 1'b1; ReqAddr = 8'h77;
    tick();
    Req = 1'b0;
    chk("ign_addr_kept", {24'd0, Address}, 32'h20);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (Done) got = 1'b1; else tick();
    end
    chk("ign_done_seen", {31'd0, got}, 32'd1);
    ref_mem[8'h20] = 32'h1234_5678;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Busy || MOV) extra++;
    end
    chk("ign_no_extra", extra, 32'd0);

    // Randomized transfers over a small address window.
    for (int n = 0; n < 24; n++) begin
      logic        r_rw;
      logic [7:0]  r_a;
      logic [31:0] r_d;
      r_rw = 1'($urandom_range(0, 1));
      r_a  = 8'h40 + 8'($urandom_range(0, 7));
      r_d  = $urandom;
      xfer(r_rw, r_a, r_d, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    // Reset asserted while the initiator waits in STROBE.
    resp_en = 1'b0;
    Req = 1'b1; ReqRW = 1'b1; ReqAddr = 8'h33;
    tick();
    Req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (MOV) got = 1'b1; else tick();
    end
    chk("rstmid_mov_seen", {31'd0, got}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rstmid_ctrl", {26'd0, Enable, MOV, RW, Busy, Done, Error}, 32'd0);
    chk("rstmid_addr", {24'd0, Address}, 32'd0);
    chk("rstmid_wdata", MemDataOut, 32'd0);
    chk("rstmid_rddata", RdData, 32'd0);
    last_rd = 32'h0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Done || Busy || Enable) bad = 1'b1;
    end
    chk("rstmid_stays_idle", {31'd0, bad}, 32'd0);
    resp_en = 1'b1;
    xfer(1'b1, 8'h20, 32'h0, 1, 2);

`ifdef MEM_TIMEOUT_EN
    // Timeout: MOC never arrives; abort exactly TIMEOUT cycles into STROBE.
    resp_en = 1'b0;
    Req = 1'b1; ReqRW = 1'b1; ReqAddr = 8'h44;
    tick();
    Req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (MOV) got = 1'b1; else tick();
    end
    strobe_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (Done) got = 1'b1; else tick();
    end
    chk("to_done_seen", {31'd0, got}, 32'd1);
    chk("to_latency", cyc - strobe_cyc, 32'd8);
    chk("to_flags", {29'd0, Error, MOV, Enable}, 32'h4);
    chk("to_rddata_kept", RdData, last_rd);
    tick();
    chk("to_after", {29'd0, Busy, Done, Error}, 32'd0);
    resp_en = 1'b1;
`else
    strobe_cyc = 0;
    chk("no_to_error", {31'd0, Error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
